// File: rtl/addsub_serie_ctrl_pkg.sv
// rtl/addsub_serie_ctrl_pkg.sv - shared constants for the bit-serial add/sub sequencer
package addsub_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic OP_SUMA  = 1'b0;
    localparam logic OP_RESTA = 1'b1;

endpackage

// File: rtl/addsub_serie_ctrl_celda.sv
// rtl/addsub_serie_ctrl_celda.sv - 1-bit full adder, full subtractor and the op-muxed cell
module sumador_1b (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module restador_1b (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic R,
    output logic Bout
);
    assign R    = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);
endmodule

module celda_addsub_1b
    import addsub_pkg::*;
(
    input  logic A,
    input  logic B,
    input  logic Cin,
    input  logic op,
    output logic S,
    output logic Cout
);
    logic s_sum, c_sum, r_res, b_res;

    sumador_1b u_sum (.A(A), .B(B), .Cin(Cin), .S(s_sum), .Cout(c_sum));
    restador_1b u_res (.A(A), .B(B), .Bin(Cin), .R(r_res), .Bout(b_res));

    // Cin doubles as the borrow-in when subtracting
    assign S    = (op == OP_RESTA) ? r_res : s_sum;
    assign Cout = (op == OP_RESTA) ? b_res : c_sum;
endmodule

// File: rtl/addsub_serie_ctrl.sv
// rtl/addsub_serie_ctrl.sv - bit-serial add/sub sequencer, optional ovf output via ADDSUB_SERIE_OVF_EN
module addsub_serie_ctrl
    import addsub_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] R,
    output logic         C
`ifdef ADDSUB_SERIE_OVF_EN
    ,
    output logic         ovf
`endif
);
    localparam int CW = $clog2(N);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  a_sr;
    logic [N-1:0]  b_sr;
    logic [N-1:0]  r_sr;
    logic          cy;
    logic          op_q;
    logic          s_bit;
    logic          co_bit;

    celda_addsub_1b u_celda (
        .A    (a_sr[0]),
        .B    (b_sr[0]),
        .Cin  (cy),
        .op   (op_q),
        .S    (s_bit),
        .Cout (co_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            cy    <= 1'b0;
            op_q  <= OP_SUMA;
            R     <= '0;
            C     <= 1'b0;
`ifdef ADDSUB_SERIE_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CALC;
                        a_sr  <= A;
                        b_sr  <= B;
                        op_q  <= op;
                        cnt   <= '0;
                        cy    <= 1'b0;
                    end
                end
                CALC: begin
                    r_sr <= {s_bit, r_sr[N-1:1]};
                    cy   <= co_bit;
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        state <= DONE;
                        R     <= {s_bit, r_sr[N-1:1]};
                        C     <= co_bit;
`ifdef ADDSUB_SERIE_OVF_EN
                        // cy is the carry/borrow into the MSB on this last bit cycle
                        ovf   <= cy ^ co_bit;
`endif
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

endmodule

// File: tb/tb_addsub_serie_ctrl.sv
// tb/tb_addsub_serie_ctrl.sv - randomized and directed checks of addsub_serie_ctrl against a behavioural model
module tb_addsub_serie_ctrl;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] R;
    logic         C;
`ifdef ADDSUB_SERIE_OVF_EN
    logic         ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    addsub_serie_ctrl #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .R     (R),
        .C     (C)
`ifdef ADDSUB_SERIE_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: edge-indexed timeline of one operation at a time
    int  e = 0;
    int  e0 = 0;
    int  avail = 0;
    bit  valid = 0;
    bit  active = 0;
    int  pr, pc, po;
    int  m_r = 0, m_c = 0, m_o = 0;

    always @(posedge clk) begin
        int a, b, r;
        e++;
        if (!rst_n) begin
            valid  = 1;
            active = 0;
            m_r = 0; m_c = 0; m_o = 0;
            avail  = e + 1;
        end else if (valid) begin
            if (active && e == e0 + N) begin
                m_r = pr; m_c = pc; m_o = po;
            end
            if (e >= avail && start) begin
                a = int'(A); b = int'(B);
                if (op) begin
                    r  = (a - b) & ((1 << N) - 1);
                    pc = (a < b) ? 1 : 0;
                    po = (((a >> (N-1)) & 1) != ((b >> (N-1)) & 1)) &&
                         (((r >> (N-1)) & 1) != ((a >> (N-1)) & 1)) ? 1 : 0;
                end else begin
                    r  = (a + b) & ((1 << N) - 1);
                    pc = ((a + b) >> N) & 1;
                    po = (((a >> (N-1)) & 1) == ((b >> (N-1)) & 1)) &&
                         (((r >> (N-1)) & 1) != ((a >> (N-1)) & 1)) ? 1 : 0;
                end
                pr     = r;
                e0     = e;
                active = 1;
                avail  = e + N + 2;
            end
        end
        #1;
        if (valid) begin
            check("busy", int'(busy), (active && e >= e0 && e < e0 + N) ? 1 : 0);
            check("done", int'(done), (active && e == e0 + N) ? 1 : 0);
            check("R", int'(R), m_r);
            check("C", int'(C), m_c);
`ifdef ADDSUB_SERIE_OVF_EN
            check("ovf", int'(ovf), m_o);
`endif
        end
    end

    task automatic run_op(input logic o, input int a, input int b,
                          input int exp_r, input int exp_c, input int exp_o, input string tag);
        int lat;
        @(negedge clk);
        start = 1'b1; op = o; A = N'(a); B = N'(b);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, N);
        check({tag, "_R"}, int'(R), exp_r);
        check({tag, "_C"}, int'(C), exp_c);
`ifdef ADDSUB_SERIE_OVF_EN
        check({tag, "_ovf"}, int'(ovf), exp_o);
`else
        if (exp_o < 0) check({tag, "_ovf_arg"}, exp_o, 0);
`endif
        @(negedge clk);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_R", int'(R), 0);
        check("rst_C", int'(C), 0);
        rst_n = 1'b1;

        run_op(1'b0, 5, 3, 8, 0, 1, "suma_5_3");
        run_op(1'b0, 9, 8, 1, 1, 1, "suma_9_8");
        run_op(1'b1, 3, 5, 14, 1, 0, "resta_3_5");
        run_op(1'b1, 7, 7, 0, 0, 0, "resta_7_7");
        run_op(1'b0, 7, 1, 8, 0, 1, "suma_7_1");
        run_op(1'b1, 8, 1, 7, 0, 1, "resta_8_1");
        run_op(1'b0, 2, 3, 5, 0, 0, "suma_2_3");

        // restart attempt and operand change mid-CALC
        @(negedge clk);
        start = 1'b1; op = 1'b0; A = 4'd2; B = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; A = 4'd15; op = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 2;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("midcalc_latency", lat, N);
        check("midcalc_R", int'(R), 5);
        check("midcalc_C", int'(C), 0);
        repeat (2) @(negedge clk);

        // start held high for back-to-back operations
        start = 1'b1; op = 1'b0; A = 4'd1; B = 4'd1;
        repeat (20) @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);

        // reset in the middle of CALC
        start = 1'b1; op = 1'b0; A = 4'd12; B = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_R", int'(R), 0);
        check("midrst_C", int'(C), 0);
        repeat (N + 2) begin
            @(negedge clk);
            check("midrst_no_done", int'(done), 0);
        end
        run_op(1'b0, 6, 1, 7, 0, 0, "after_rst_6_1");

        // randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 59) != 0);
            start = ($urandom_range(0, 2) == 0);
            op    = 1'($urandom_range(0, 1));
            A     = N'($urandom_range(0, (1 << N) - 1));
            B     = N'($urandom_range(0, (1 << N) - 1));
        end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (N + 4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
